// File: rtl/led_fader.sv
// Breathing-LED fader: a RISE/HOLD_HI/FALL/HOLD_LO ramp drives eight PWM channels, with even and odd channels fading in opposite directions.
// Optional build macro LED_FADE_GAMMA_EN squares the duty (upper byte of d*d) for a perceptual curve.
module led_fader #(
  parameter int STEP_DIV   = 195312,
  parameter int HOLD_STEPS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] mask,
  output logic [7:0] led,
  output logic [7:0] level,
  output logic [1:0] state,
  output logic       cycle_done
);

  localparam int SW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [7:0]    HOLD_LAST = 8'(HOLD_STEPS - 1);

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } fade_state_t;

  fade_state_t   cur_state;
  fade_state_t   nxt_state;
  logic [7:0]    pwm_cnt;
  logic [SW-1:0] step_cnt;
  logic [7:0]    hold_cnt;
  logic [7:0]    nxt_level;
  logic [7:0]    nxt_hold;
  logic          nxt_done;
  logic [7:0]    duty_even;
  logic [7:0]    duty_odd;
  logic          tick;
  logic          even_on;
  logic          odd_on;

  function automatic logic [7:0] shape(input logic [7:0] d);
`ifdef LED_FADE_GAMMA_EN
    logic [15:0] p;
    p = {8'd0, d} * {8'd0, d};
    return p[15:8];
`else
    return d;
`endif
  endfunction

  assign tick    = en && (step_cnt == STEP_LAST);
  assign even_on = pwm_cnt < duty_even;
  assign odd_on  = pwm_cnt < duty_odd;
  assign state   = cur_state;

  // Ramp sequencing; only a step tick moves the level or the state.
  always_comb begin
    nxt_state = cur_state;
    nxt_level = level;
    nxt_hold  = hold_cnt;
    nxt_done  = 1'b0;
    if (tick) begin
      case (cur_state)
        RISE: begin
          if (level == 8'd255) begin
            nxt_state = HOLD_HI;
            nxt_hold  = 8'd0;
          end else begin
            nxt_level = level + 8'd1;
          end
        end
        HOLD_HI: begin
          if (hold_cnt == HOLD_LAST) begin
            nxt_state = FALL;
          end else begin
            nxt_hold = hold_cnt + 8'd1;
          end
        end
        FALL: begin
          if (level == 8'd0) begin
            nxt_state = HOLD_LO;
            nxt_hold  = 8'd0;
          end else begin
            nxt_level = level - 8'd1;
          end
        end
        HOLD_LO: begin
          if (hold_cnt == HOLD_LAST) begin
            nxt_state = RISE;
            nxt_done  = 1'b1;
          end else begin
            nxt_hold = hold_cnt + 8'd1;
          end
        end
        default: begin
          nxt_state = RISE;
        end
      endcase
    end else begin
      nxt_state = cur_state;
    end
  end

  // All state freezes while en is low; the LEDs blank on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state  <= RISE;
      level      <= 8'd0;
      hold_cnt   <= 8'd0;
      pwm_cnt    <= 8'd0;
      step_cnt   <= '0;
      duty_even  <= 8'd0;
      duty_odd   <= 8'd0;
      led        <= 8'd0;
      cycle_done <= 1'b0;
    end else if (en) begin
      cur_state  <= nxt_state;
      level      <= nxt_level;
      hold_cnt   <= nxt_hold;
      pwm_cnt    <= pwm_cnt + 8'd1;
      step_cnt   <= tick ? '0 : step_cnt + {{(SW-1){1'b0}}, 1'b1};
      cycle_done <= nxt_done;
      led        <= mask & {4{odd_on, even_on}};
      // Duties change only at the period boundary so a period never glitches.
      if (pwm_cnt == 8'hFF) begin
        duty_even <= shape(level);
        duty_odd  <= shape(8'hFF - level);
      end
    end else begin
      led        <= 8'd0;
      cycle_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_fader.sv
// Randomized bench for led_fader (STEP_DIV=4, HOLD_STEPS=2): a tick-count model derives the
// expected level, state, cycle_done and LED pattern every cycle; async resets are probed between edges.
module tb_led_fader;

  localparam int SD = 4;
  localparam int HS = 2;
  localparam int PER = 2 * 256 + 2 * HS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] mask = 8'hFF;
  logic [7:0] led;
  logic [7:0] level;
  logic [1:0] state;
  logic       cycle_done;

  int checks = 0;
  int errors = 0;

  int         act;
  logic [7:0] m_de, m_do, m_led;
  logic       m_cd;
  int         done_seen = 0;

  led_fader #(.STEP_DIV(SD), .HOLD_STEPS(HS)) dut (
    .clk(clk), .rst(rst), .en(en), .mask(mask),
    .led(led), .level(level), .state(state), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  function automatic int lvl_of(input int ph);
    if (ph < 256) return ph;
    if (ph < 256 + HS) return 255;
    if (ph < 512 + HS) return 255 - (ph - 256 - HS);
    return 0;
  endfunction

  function automatic int st_of(input int ph);
    if (ph < 256) return 0;
    if (ph < 256 + HS) return 1;
    if (ph < 512 + HS) return 2;
    return 3;
  endfunction

  function automatic logic [7:0] gam(input int d);
`ifdef LED_FADE_GAMMA_EN
    return 8'((d * d) / 256);
`else
    return 8'(d);
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    act = 0; m_de = 8'd0; m_do = 8'd0; m_led = 8'd0; m_cd = 1'b0;
  endtask

  task automatic model_edge();
    int ph, pwm, lv;
    if (en) begin
      pwm = act % 256;
      ph  = (act / SD) % PER;
      lv  = lvl_of(ph);
      for (int i = 0; i < 8; i++)
        m_led[i] = mask[i] & (pwm < ((i % 2 == 0) ? int'(m_de) : int'(m_do)));
      m_cd = ((act % SD) == SD - 1) && (ph == PER - 1);
      if (pwm == 255) begin
        m_de = gam(lv);
        m_do = gam(255 - lv);
      end
      act++;
    end else begin
      m_led = 8'd0;
      m_cd  = 1'b0;
    end
  endtask

  task automatic check_all();
    int ph;
    ph = (act / SD) % PER;
    check("level", level, 8'(lvl_of(ph)));
    check("state", {6'd0, state}, 8'(st_of(ph)));
    check("cycle_done", {7'd0, cycle_done}, {7'd0, m_cd});
    check("led", led, m_led);
  endtask

  task automatic check_reset_vals();
    check("rst_level", level, 8'd0);
    check("rst_state", {6'd0, state}, 8'd0);
    check("rst_cycle_done", {7'd0, cycle_done}, 8'd0);
    check("rst_led", led, 8'd0);
  endtask

  initial begin
    int freeze;
    freeze = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    en  = 1'b1;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(posedge clk);
      if (!rst) model_edge();
      @(negedge clk);
      check_all();
      if (cycle_done) done_seen++;
      if (rst) begin
        rst = 1'b0;
      end else if (cyc == 1500 || cyc == 5200) begin
        #1 rst = 1'b1;
        #1 check_reset_vals();
        model_reset();
      end
      if (freeze > 0) begin
        freeze--;
        en = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        freeze = $urandom_range(1, 50);
        en = 1'b0;
      end else begin
        en = ($urandom_range(0, 19) != 0);
      end
      if ($urandom_range(0, 39) == 0) mask = 8'($urandom);
    end
    checks++;
    assert (done_seen >= 1) else begin
      errors++;
      $error("FAIL cycle_done_count observed=%0d expected>=1", done_seen);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
